// File: rtl/m6502_ea_sequencer.sv
// Effective-address and operand-access sequencer for the m6502 core family.
// Resolves one addressing mode through byte-wide bus reads, then performs the data load or store.
module m6502_ea_sequencer #(
  parameter int          ADDR_WIDTH         = 16,
  parameter logic [15:0] ZP_BASE            = 16'h0000,
  parameter bit          JMP_IND_BUG        = 1'b1,
  parameter bit          PAGE_CROSS_PENALTY = 1'b1,
  parameter logic [15:0] RESET_VECTOR       = 16'hFFFC,
  localparam int         BW = (ADDR_WIDTH > 16) ? ADDR_WIDTH - 16 : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [3:0]            mode,
  input  logic [1:0]            op,
  input  logic [15:0]           pc_op,
  input  logic [7:0]            idx_x,
  input  logic [7:0]            idx_y,
  input  logic [BW-1:0]         bank,
  input  logic [7:0]            st_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           ea,
  output logic [7:0]            ld_data,
  output logic                  page_cross,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_rd_req,
  output logic                  bus_wr_en,
  output logic [7:0]            bus_wr_data,
  input  logic [7:0]            bus_rd_data,
  input  logic                  bus_ready,
  output logic [2:0]            dbg_state
);

  // Bus handshake: a request (bus_rd_req or bus_wr_en) and bus_addr stay constant
  // until a cycle with bus_ready=1; that cycle completes the access and read data is
  // taken from bus_rd_data. At most one access is outstanding.

  typedef enum logic [2:0] {
    S_IDLE, S_OP1, S_OP2, S_PTR_LO, S_PTR_HI, S_PENALTY, S_DATA, S_DONE
  } state_t;

  localparam logic [3:0] M_IMM = 4'd0, M_Z = 4'd1, M_ZX = 4'd2, M_ZY = 4'd3,
                         M_ABS = 4'd4, M_ABSX = 4'd5, M_ABSY = 4'd6, M_INDX = 4'd7,
                         M_INDY = 4'd8, M_INDABS = 4'd9, M_RESET = 4'd10;
  localparam logic [1:0] OP_ADDR = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2;

  state_t        state_q, state_d, after_addr;
  logic [3:0]    mode_q, mode_d, mode_n;
  logic [1:0]    op_q, op_d, op_n;
  logic [15:0]   pc_q, pc_d;
  logic [7:0]    x_q, x_d, y_q, y_d, st_q, st_d;
  logic [BW-1:0] bank_q, bank_d;
  logic [7:0]    b1_q, b1_d, b2_q, b2_d, plo_q, plo_d, phi_q, phi_d;
  logic [15:0]   ea_q, ea_d;
  logic [7:0]    ld_q, ld_d;
  logic          pcx_q, pcx_d;

  logic [15:0]   a16, base, ea_calc;
  logic [7:0]    zx, zx1, z1, zidx, zsum, aidx;
  logic          rd, wr, use_bank, cross_calc;

  always_comb begin
    mode_n = (mode > M_RESET) ? M_IMM : mode;
    op_n   = (op == 2'd3) ? OP_LOAD : op;
    if (mode_n == M_INDABS || mode_n == M_RESET) op_n = OP_ADDR;
    else if (mode_n == M_IMM && op_n == OP_STORE) op_n = OP_LOAD;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    op_d    = op_q;
    pc_d    = pc_q;
    x_d     = x_q;
    y_d     = y_q;
    bank_d  = bank_q;
    st_d    = st_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    plo_d   = plo_q;
    phi_d   = phi_q;
    ea_d    = ea_q;
    ld_d    = ld_q;
    pcx_d   = pcx_q;
    a16      = 16'h0000;
    rd       = 1'b0;
    wr       = 1'b0;
    use_bank = 1'b0;
    zx  = b1_q + x_q;
    zx1 = zx + 8'd1;
    z1  = b1_q + 8'd1;

    // Access address for the current state; operand/pointer fetches stay in bank 0.
    case (state_q)
      S_OP1: begin
        rd  = 1'b1;
        a16 = pc_q;
      end
      S_OP2: begin
        rd  = 1'b1;
        a16 = pc_q + 16'd1;
      end
      S_PTR_LO: begin
        rd = 1'b1;
        case (mode_q)
          M_INDX:   a16 = ZP_BASE + {8'h00, zx};
          M_INDY:   a16 = ZP_BASE + {8'h00, b1_q};
          M_INDABS: a16 = {b2_q, b1_q};
          default:  a16 = RESET_VECTOR;
        endcase
      end
      S_PTR_HI: begin
        rd = 1'b1;
        case (mode_q)
          M_INDX:   a16 = ZP_BASE + {8'h00, zx1};
          M_INDY:   a16 = ZP_BASE + {8'h00, z1};
          M_INDABS: a16 = JMP_IND_BUG ? {b2_q, z1} : ({b2_q, b1_q} + 16'd1);
          default:  a16 = RESET_VECTOR + 16'd1;
        endcase
      end
      S_DATA: begin
        a16      = ea_q;
        use_bank = (mode_q != M_IMM);
        rd       = (op_q == OP_LOAD);
        wr       = (op_q == OP_STORE);
      end
      default: ;
    endcase

    if (bus_ready && rd) begin
      case (state_q)
        S_OP1:    b1_d  = bus_rd_data;
        S_OP2:    b2_d  = bus_rd_data;
        S_PTR_LO: plo_d = bus_rd_data;
        S_PTR_HI: phi_d = bus_rd_data;
        S_DATA:   ld_d  = bus_rd_data;
        default: ;
      endcase
    end

    // Address from the bytes as they stand after this cycle's capture.
    zidx = (mode_q == M_ZX) ? x_q : ((mode_q == M_ZY) ? y_q : 8'h00);
    aidx = (mode_q == M_ABSX) ? x_q : ((mode_q == M_ABSY) ? y_q : 8'h00);
    zsum = b1_d + zidx;
    base = 16'h0000;
    cross_calc = 1'b0;
    case (mode_q)
      M_Z, M_ZX, M_ZY: ea_calc = ZP_BASE + {8'h00, zsum};
      M_ABS, M_ABSX, M_ABSY: begin
        base       = {b2_d, b1_d};
        ea_calc    = base + {8'h00, aidx};
        cross_calc = (mode_q != M_ABS) && (ea_calc[15:8] != base[15:8]);
      end
      M_INDY: begin
        base       = {phi_d, plo_d};
        ea_calc    = base + {8'h00, y_q};
        cross_calc = (ea_calc[15:8] != base[15:8]);
      end
      M_INDX, M_INDABS, M_RESET: ea_calc = {phi_d, plo_d};
      default: ea_calc = ea_q;
    endcase

    if (op_q == OP_ADDR) after_addr = S_DONE;
    else if (cross_calc && PAGE_CROSS_PENALTY) after_addr = S_PENALTY;
    else after_addr = S_DATA;

    if (state_q == S_OP1 || state_q == S_OP2 || state_q == S_PTR_LO || state_q == S_PTR_HI) begin
      ea_d  = ea_calc;
      pcx_d = cross_calc;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode_n;
          op_d   = op_n;
          pc_d   = pc_op;
          x_d    = idx_x;
          y_d    = idx_y;
          bank_d = bank;
          st_d   = st_data;
          pcx_d  = 1'b0;
          if (mode_n == M_IMM) begin
            ea_d    = pc_op;
            state_d = (op_n == OP_ADDR) ? S_DONE : S_DATA;
          end else if (mode_n == M_RESET) begin
            state_d = S_PTR_LO;
          end else begin
            state_d = S_OP1;
          end
        end
      end
      S_OP1: begin
        if (bus_ready) begin
          case (mode_q)
            M_Z, M_ZX, M_ZY:                 state_d = after_addr;
            M_INDX, M_INDY:                  state_d = S_PTR_LO;
            default:                         state_d = S_OP2;
          endcase
        end
      end
      S_OP2: begin
        if (bus_ready) state_d = (mode_q == M_INDABS) ? S_PTR_LO : after_addr;
      end
      S_PTR_LO:  if (bus_ready) state_d = S_PTR_HI;
      S_PTR_HI:  if (bus_ready) state_d = after_addr;
      S_PENALTY: state_d = S_DATA;
      S_DATA:    if (bus_ready) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_IMM;
      op_q    <= OP_ADDR;
      pc_q    <= 16'h0000;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      bank_q  <= '0;
      st_q    <= 8'h00;
      b1_q    <= 8'h00;
      b2_q    <= 8'h00;
      plo_q   <= 8'h00;
      phi_q   <= 8'h00;
      ea_q    <= 16'h0000;
      ld_q    <= 8'h00;
      pcx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bank_q  <= bank_d;
      st_q    <= st_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      plo_q   <= plo_d;
      phi_q   <= phi_d;
      ea_q    <= ea_d;
      ld_q    <= ld_d;
      pcx_q   <= pcx_d;
    end
  end

  generate
    if (ADDR_WIDTH > 16) begin : g_bank
      assign bus_addr = {(use_bank ? bank_q : {BW{1'b0}}), a16};
    end else begin : g_nobank
      assign bus_addr = a16;
    end
  endgenerate

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign ea          = ea_q;
  assign ld_data     = ld_q;
  assign page_cross  = pcx_q;
  assign bus_rd_req  = rd;
  assign bus_wr_en   = wr;
  assign bus_wr_data = wr ? st_q : 8'h00;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_m6502_ea_sequencer.sv
// Bench for m6502_ea_sequencer: two configurations share one memory model; an access
// scoreboard and a completion scoreboard check the traffic and the results.
module tb_m6502_ea_sequencer;

  localparam int W = 34; // {latency[7:0], ea[15:0], ld[7:0], chk_ld, page_cross}
  localparam logic [3:0] M_IMM = 4'd0, M_Z = 4'd1, M_ZX = 4'd2, M_ABS = 4'd4,
                         M_ABSX = 4'd5, M_ABSY = 4'd6, M_INDX = 4'd7, M_INDY = 4'd8,
                         M_INDABS = 4'd9, M_RESET = 4'd10;
  localparam logic [1:0] OP_ADDR = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2;

  logic clk = 1'b0;
  logic reset_n;
  logic start_a, start_b;
  logic [3:0] mode;
  logic [1:0] op;
  logic [15:0] pc_op;
  logic [7:0] idx_x, idx_y, st_data, bank_b;
  logic bank_a;

  logic busy_a, done_a, pcx_a, rd_a, wr_a, ready_a;
  logic [15:0] ea_a, addr_a;
  logic [7:0] ld_a, wdat_a, rdat_a;
  logic [2:0] dbg_a;
  logic busy_b, done_b, pcx_b, rd_b, wr_b, ready_b;
  logic [15:0] ea_b;
  logic [23:0] addr_b;
  logic [7:0] ld_b, wdat_b, rdat_b;
  logic [2:0] dbg_b;

  logic [7:0] mem [0:65535];
  logic [W-1:0] exp_q[$];
  logic [32:0] acc_q[$]; // {wr, addr[23:0], wdata}
  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0, stall_n = 0, wr_cycles = 0;
  int cnt [2];
  logic [25:0] held [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  m6502_ea_sequencer dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .mode(mode), .op(op), .pc_op(pc_op),
    .idx_x(idx_x), .idx_y(idx_y), .bank(bank_a), .st_data(st_data),
    .busy(busy_a), .done(done_a), .ea(ea_a), .ld_data(ld_a), .page_cross(pcx_a),
    .bus_addr(addr_a), .bus_rd_req(rd_a), .bus_wr_en(wr_a), .bus_wr_data(wdat_a),
    .bus_rd_data(rdat_a), .bus_ready(ready_a), .dbg_state(dbg_a)
  );

  m6502_ea_sequencer #(
    .ADDR_WIDTH(24), .ZP_BASE(16'h2000), .JMP_IND_BUG(1'b0), .PAGE_CROSS_PENALTY(1'b0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .mode(mode), .op(op), .pc_op(pc_op),
    .idx_x(idx_x), .idx_y(idx_y), .bank(bank_b), .st_data(st_data),
    .busy(busy_b), .done(done_b), .ea(ea_b), .ld_data(ld_b), .page_cross(pcx_b),
    .bus_addr(addr_b), .bus_rd_req(rd_b), .bus_wr_en(wr_b), .bus_wr_data(wdat_b),
    .bus_rd_data(rdat_b), .bus_ready(ready_b), .dbg_state(dbg_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_rd(input logic [23:0] a);
    acc_q.push_back({1'b0, a, 8'h00});
  endtask

  task automatic push_wr(input logic [23:0] a, input logic [7:0] d);
    acc_q.push_back({1'b1, a, d});
  endtask

  // Memory responder: stalls each access for stall_n cycles, then completes it.
  task automatic serve(input int i, input logic rd, input logic wr, input logic [23:0] a,
                       input logic [7:0] wd, output logic rdy, output logic [7:0] rdat);
    logic [32:0] e;
    rdy  = 1'b0;
    rdat = 8'hEE;
    if (rd || wr) begin
      if (wr) wr_cycles++;
      if (rd && wr) chk("rd_wr_together", 1, 0);
      if (cnt[i] > 0) chk("stall_hold", {6'd0, rd, wr, a}, {6'd0, held[i]});
      held[i] = {rd, wr, a};
      if (cnt[i] >= stall_n) begin
        rdy = 1'b1;
        cnt[i] = 0;
        if (rd) rdat = mem[a[15:0]];
        if (acc_q.size() == 0) begin
          chk("unexpected_access", {7'd0, wr, a}, 32'hFFFF_FFFF);
        end else begin
          e = acc_q.pop_front();
          chk("access", {wr, a, (wr ? wd : 8'h00)}, e[31:0]);
          chk("access_dir", {31'd0, wr}, {31'd0, e[32]});
        end
        if (wr) mem[a[15:0]] = wd;
      end else begin
        cnt[i] = cnt[i] + 1;
      end
    end else begin
      cnt[i] = 0;
    end
  endtask

  always @(negedge clk) serve(0, rd_a, wr_a, {8'h00, addr_a}, wdat_a, ready_a, rdat_a);
  always @(negedge clk) serve(1, rd_b, wr_b, addr_b, wdat_b, ready_b, rdat_b);

  // Completion monitor.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (done_a === 1'b1 || done_b === 1'b1) begin
      if (done_a === 1'b1 && done_b === 1'b1) chk("both_done", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {15'd0, done_b, 15'd0, done_a}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("latency", cyc - start_cyc, {24'd0, e[33:26]});
        chk("ea", {16'd0, done_a ? ea_a : ea_b}, {16'd0, e[25:10]});
        chk("page_cross", {31'd0, done_a ? pcx_a : pcx_b}, {31'd0, e[0]});
        if (e[1]) chk("ld_data", {24'd0, done_a ? ld_a : ld_b}, {24'd0, e[9:2]});
      end
    end
  end

  task automatic run_op(input bit inst_b, input logic [3:0] m, input logic [1:0] o,
                        input logic [15:0] pc, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] bnk, input logic [7:0] st, input bit glitch,
                        input logic [7:0] lat, input logic [15:0] e_ea, input logic [7:0] e_ld,
                        input logic e_chk, input logic e_pcx);
    exp_q.push_back({lat, e_ea, e_ld, e_chk, e_pcx});
    @(negedge clk);
    mode = m; op = o; pc_op = pc; idx_x = x; idx_y = y; bank_b = bnk; st_data = st;
    if (inst_b) start_b = 1'b1; else start_a = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    chk("busy_after_start", {31'd0, inst_b ? busy_b : busy_a}, 1);
    if (glitch) begin
      mode = M_RESET; pc_op = 16'hDEAD; idx_x = 8'h77; st_data = 8'h00;
      if (inst_b) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
    end
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    chk("op_complete_timeout", exp_q.size(), 0);
    exp_q.delete();
    chk("accesses_left", acc_q.size(), 0);
    acc_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    start_a = 0; start_b = 0; mode = 0; op = 0; pc_op = 0; idx_x = 0; idx_y = 0;
    st_data = 0; bank_a = 0; bank_b = 0; reset_n = 0;
    cnt[0] = 0; cnt[1] = 0; held[0] = '0; held[1] = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0200] = 8'hF0; mem[16'h0010] = 8'h5A;
    mem[16'h0210] = 8'h40; mem[16'h0040] = 8'hFF; mem[16'h0041] = 8'h12; mem[16'h1300] = 8'h77;
    mem[16'h0220] = 8'hFF; mem[16'h0221] = 8'h30;
    mem[16'h30FF] = 8'h34; mem[16'h3000] = 8'h12; mem[16'h3100] = 8'h99;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hE0;
    mem[16'h0230] = 8'hF0; mem[16'h0231] = 8'h12;
    mem[16'h0240] = 8'h00; mem[16'h0241] = 8'h05; mem[16'h0500] = 8'h3C;
    mem[16'h0250] = 8'hF0; mem[16'h0251] = 8'h12; mem[16'h1310] = 8'hC3;
    mem[16'h0260] = 8'hFE; mem[16'h00FF] = 8'h00; mem[16'h0000] = 8'h44; mem[16'h4400] = 8'hE7;
    mem[16'h0270] = 8'h9D; mem[16'h0280] = 8'h33;
    mem[16'h0300] = 8'h10; mem[16'h2010] = 8'hB4;
    mem[16'h0310] = 8'hFF; mem[16'h0311] = 8'h30;
    mem[16'h0320] = 8'hF0; mem[16'h0321] = 8'h12;
    mem[16'h0330] = 8'h50; mem[16'h2050] = 8'h00; mem[16'h2051] = 8'h40;

    repeat (3) @(negedge clk);
    chk("rst_busy_a", {31'd0, busy_a}, 0);
    chk("rst_done_a", {31'd0, done_a}, 0);
    chk("rst_req_a", {30'd0, rd_a, wr_a}, 0);
    chk("rst_pcx_a", {31'd0, pcx_a}, 0);
    chk("rst_ea_a", {16'd0, ea_a}, 0);
    chk("rst_ld_a", {24'd0, ld_a}, 0);
    chk("rst_addr_a", {16'd0, addr_a}, 0);
    chk("rst_wdata_a", {24'd0, wdat_a}, 0);
    chk("rst_b", {busy_b, done_b, rd_b, wr_b, pcx_b, addr_b}, 0);
    reset_n = 1;
    @(negedge clk);

    // Z_X with zero-page wrap: F0+20 -> 10
    push_rd(24'h000200); push_rd(24'h000010);
    run_op(0, M_ZX, OP_LOAD, 16'h0200, 8'h20, 8'h00, 8'h00, 8'h00, 0, 8'd3, 16'h0010, 8'h5A, 1, 0);
    // IND_Y page cross with penalty
    push_rd(24'h000210); push_rd(24'h000040); push_rd(24'h000041); push_rd(24'h001300);
    run_op(0, M_INDY, OP_LOAD, 16'h0210, 8'h00, 8'h01, 8'h00, 8'h00, 0, 8'd6, 16'h1300, 8'h77, 1, 1);
    // JMP indirect with page-wrap quirk: hi byte from 3000
    push_rd(24'h000220); push_rd(24'h000221); push_rd(24'h0030FF); push_rd(24'h003000);
    run_op(0, M_INDABS, OP_LOAD, 16'h0220, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'd5, 16'h1234, 8'h00, 0, 0);
    // RESET vector fetch
    push_rd(24'h00FFFC); push_rd(24'h00FFFD);
    run_op(0, M_RESET, OP_STORE, 16'h1111, 8'h00, 8'h00, 8'h00, 8'h55, 0, 8'd3, 16'hE000, 8'h00, 0, 0);
    // STORE ABS_X with 3 stall cycles on every access
    stall_n = 3; wr_cycles = 0;
    push_rd(24'h000230); push_rd(24'h000231); push_wr(24'h0012F5, 8'hA5);
    run_op(0, M_ABSX, OP_STORE, 16'h0230, 8'h05, 8'h00, 8'h00, 8'hA5, 0, 8'd13, 16'h12F5, 8'h00, 0, 0);
    chk("wr_en_cycles", wr_cycles, 4);
    chk("store_mem", {24'd0, mem[16'h12F5]}, 32'h0000_00A5);
    stall_n = 0;
    // ABS LOAD with a start pulse while busy
    push_rd(24'h000240); push_rd(24'h000241); push_rd(24'h000500);
    run_op(0, M_ABS, OP_LOAD, 16'h0240, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'd4, 16'h0500, 8'h3C, 1, 0);
    // ABS_Y page cross with penalty
    push_rd(24'h000250); push_rd(24'h000251); push_rd(24'h001310);
    run_op(0, M_ABSY, OP_LOAD, 16'h0250, 8'h00, 8'h20, 8'h00, 8'h00, 0, 8'd5, 16'h1310, 8'hC3, 1, 1);
    // IND_X pointer wrapping from FF to 00
    push_rd(24'h000260); push_rd(24'h0000FF); push_rd(24'h000000); push_rd(24'h004400);
    run_op(0, M_INDX, OP_LOAD, 16'h0260, 8'h01, 8'h00, 8'h00, 8'h00, 0, 8'd5, 16'h4400, 8'hE7, 1, 0);
    // IMM LOAD and Z ADDR_ONLY
    push_rd(24'h000270);
    run_op(0, M_IMM, OP_LOAD, 16'h0270, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'd2, 16'h0270, 8'h9D, 1, 0);
    push_rd(24'h000280);
    run_op(0, M_Z, OP_ADDR, 16'h0280, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'd2, 16'h0033, 8'h00, 0, 0);

    // Banked configuration, ZP_BASE=2000, no JMP quirk, no penalty
    push_rd(24'h000300); push_rd(24'h072010);
    run_op(1, M_Z, OP_LOAD, 16'h0300, 8'h00, 8'h00, 8'h07, 8'h00, 0, 8'd3, 16'h2010, 8'hB4, 1, 0);
    push_rd(24'h000310); push_rd(24'h000311); push_rd(24'h0030FF); push_rd(24'h003100);
    run_op(1, M_INDABS, OP_ADDR, 16'h0310, 8'h00, 8'h00, 8'h07, 8'h00, 0, 8'd5, 16'h9934, 8'h00, 0, 0);
    push_rd(24'h000320); push_rd(24'h000321); push_rd(24'h071310);
    run_op(1, M_ABSX, OP_LOAD, 16'h0320, 8'h20, 8'h00, 8'h07, 8'h00, 0, 8'd4, 16'h1310, 8'hC3, 1, 1);
    push_rd(24'h000330); push_rd(24'h002050); push_rd(24'h002051); push_wr(24'h074002, 8'h5E);
    run_op(1, M_INDY, OP_STORE, 16'h0330, 8'h00, 8'h02, 8'h07, 8'h5E, 0, 8'd5, 16'h4002, 8'h00, 0, 0);
    chk("store_mem_b", {24'd0, mem[16'h4002]}, 32'h0000_005E);

    // Reset while PTR_HI is stalled: request drops, no done, next start works
    stall_n = 3;
    push_rd(24'h00FFFC);
    @(negedge clk);
    mode = M_RESET; op = OP_ADDR; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 50 && !(rd_a === 1'b1 && addr_a == 16'hFFFD); k++) @(negedge clk);
    chk("ptr_hi_reached", {15'd0, rd_a, addr_a}, 32'h0001_FFFD);
    reset_n = 0;
    @(negedge clk);
    chk("abort_req", {29'd0, rd_a, wr_a, busy_a}, 0);
    reset_n = 1;
    stall_n = 0;
    repeat (4) @(negedge clk);
    chk("abort_accesses", acc_q.size(), 0);
    acc_q.delete();
    push_rd(24'h000270);
    run_op(0, M_IMM, OP_LOAD, 16'h0270, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'd2, 16'h0270, 8'h9D, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
